// File: rtl/vector_pkg.sv
// Shared vector-datapath definitions: lane geometry, memory depth and LSU state encoding.
package vector_pkg;

  localparam int LANES     = 16;
  localparam int LANE_W    = 16;
  localparam int ADDR_W    = 32;
  localparam int MEM_DEPTH = 2048;
  localparam int VL_W      = 5;

  typedef logic [LANES-1:0][ADDR_W-1:0] addr_vec_t;
  typedef logic [LANES-1:0][LANE_W-1:0] data_vec_t;

  typedef enum logic [2:0] {IDLE, CALC, READ, WRITE, RESP} lsu_state_t;

endpackage

// File: rtl/vector_lsu_if.sv
// Request/response channel between the MEM stage (master) and the vector LSU (slave).
interface vector_lsu_if;
  import vector_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [ADDR_W-1:0] req_base;
  logic [ADDR_W-1:0] req_stride;
  logic [VL_W-1:0]   req_vl;
  data_vec_t         req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  data_vec_t         resp_rdata;
  logic              resp_fault;

  modport master (
    output req_valid, req_store, req_base, req_stride, req_vl, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_store, req_base, req_stride, req_vl, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );

endinterface

// File: rtl/vector_addr_gen.sv
// Strided lane address generator: active mask, bounds fault, and inactive lanes
// replicating the last active lane so their writes are harmless duplicates.
module vector_addr_gen
  import vector_pkg::*;
(
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  input  logic [VL_W-1:0]   vl,
  output addr_vec_t         addr,
  output logic [LANES-1:0]  mask,
  output logic              fault
);

  addr_vec_t raw;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    raw   = '0;
    addr  = '0;
    mask  = '0;
    fault = 1'b0;

    raw[0] = base;
    for (int i = 1; i < LANES; i++) raw[i] = raw[i-1] + stride;

    mask[0] = (vl != '0);
    addr[0] = raw[0];
    if (mask[0] && raw[0] >= ADDR_W'(MEM_DEPTH)) fault = 1'b1;

    // Inactive lanes carry the previous lane forward, i.e. lane vl-1.
    for (int i = 1; i < LANES; i++) begin
      mask[i] = (VL_W'(i) < vl);
      addr[i] = mask[i] ? raw[i] : addr[i-1];
      if (mask[i] && raw[i] >= ADDR_W'(MEM_DEPTH)) fault = 1'b1;
    end
  end

endmodule

// File: rtl/vector_lsu.sv
// Vector load/store unit: accepts one strided request, drives the 16-lane memory,
// and returns load data or a bounds-fault response.
module vector_lsu
  import vector_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  vector_lsu_if.slave  bus,
  output addr_vec_t    mem_addr,
  output logic         mem_we,
  output data_vec_t    mem_wd,
  input  data_vec_t    mem_rd
);

  lsu_state_t        state, state_n;
  logic              store_q;
  logic [ADDR_W-1:0] base_q, stride_q;
  logic [VL_W-1:0]   vl_q;
  data_vec_t         wdata_q, rdata_q, merged, rd_masked;
  logic              fault_q;

  addr_vec_t         gen_addr;
  logic [LANES-1:0]  gen_mask;
  logic              gen_fault;

  vector_addr_gen u_addr_gen (
    .base   (base_q),
    .stride (stride_q),
    .vl     (vl_q),
    .addr   (gen_addr),
    .mask   (gen_mask),
    .fault  (gen_fault)
  );

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (bus.req_valid) state_n = CALC;
      CALC:  if (gen_fault || vl_q == '0) state_n = RESP;
             else if (store_q)            state_n = WRITE;
             else                         state_n = READ;
      READ:  state_n = RESP;
      WRITE: state_n = RESP;
      RESP:  if (bus.resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state == IDLE)  && !rst;
    bus.resp_valid = (state == RESP)  && !rst;
    mem_we         = (state == WRITE) && !rst;
  end

  // NOTE: the request payload has no reset; it is only consumed after an accept has loaded it.
  always_ff @(posedge clk) begin
    if (bus.req_valid && bus.req_ready) begin
      store_q  <= bus.req_store;
      base_q   <= bus.req_base;
      stride_q <= bus.req_stride;
      vl_q     <= (bus.req_vl > VL_W'(LANES)) ? VL_W'(LANES) : bus.req_vl;
      wdata_q  <= bus.req_wdata;
    end
  end

  // Inactive lanes write lane vl-1's data to lane vl-1's address: an identical duplicate.
  always_comb begin
    merged    = '0;
    rd_masked = '0;
    merged[0] = wdata_q[0];
    for (int i = 1; i < LANES; i++) merged[i] = gen_mask[i] ? wdata_q[i] : merged[i-1];
    for (int i = 0; i < LANES; i++) rd_masked[i] = gen_mask[i] ? mem_rd[i] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr <= '0;
      mem_wd   <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      case (state)
        CALC: begin
          mem_addr <= gen_addr;
          mem_wd   <= merged;
          rdata_q  <= '0;
          fault_q  <= gen_fault;
        end
        READ:    rdata_q <= rd_masked;
        default: ;
      endcase
    end
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_fault = fault_q;

endmodule

// File: tb/tb_vector_lsu.sv
// Randomized self-checking bench for vector_lsu against a lane-level memory model.
module tb_vector_lsu;
  import vector_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  always #5 clk = ~clk;

  vector_lsu_if bus ();
  logic [LANES*ADDR_W-1:0] mem_addr;
  logic                    mem_we;
  logic [LANES*LANE_W-1:0] mem_wd, mem_rd;

  vector_lsu dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd)
  );

  // Vector data memory: combinational read, synchronous write, highest lane wins.
  logic [15:0] ram       [MEM_DEPTH];
  logic [15:0] model_ram [MEM_DEPTH];

  always_comb begin
    mem_rd = '0;
    for (int i = 0; i < LANES; i++)
      if (mem_addr[32*i +: 32] < 32'(MEM_DEPTH)) mem_rd[16*i +: 16] = ram[mem_addr[32*i +: 11]];
  end

  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < MEM_DEPTH; k++) ram[k] <= 16'(k);
    end else if (mem_we) begin
      for (int i = 0; i < LANES; i++) ram[mem_addr[32*i +: 11]] <= mem_wd[16*i +: 16];
    end
  end

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  logic [255:0] exp_rdata = '0;
  logic         exp_fault = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare process: every cycle a response is presented it must match the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) we_cnt++;
      if (bus.resp_valid) begin
        check("resp_rdata", bus.resp_rdata, exp_rdata);
        check("resp_fault", 256'(bus.resp_fault), 256'(exp_fault));
        check("req_ready_busy", 256'(bus.req_ready), 256'd0);
      end
    end
  end

  // Reference: lane addresses from base + i*stride, loads read the model image,
  // stores apply active lanes in ascending order so the highest lane wins.
  task automatic model(input logic st, input logic [31:0] base, input logic [31:0] stride,
                       input logic [4:0] vl_raw, input logic [255:0] w,
                       output logic [255:0] rd, output logic flt, output int lat, output int we_exp);
    int v;
    logic [31:0] a;
    v   = (vl_raw > 5'd16) ? 16 : int'(vl_raw);
    flt = 1'b0;
    rd  = '0;
    for (int i = 0; i < v; i++) begin
      a = base + 32'(i) * stride;
      if (a >= 32'(MEM_DEPTH)) flt = 1'b1;
    end
    if (!flt && v > 0) begin
      for (int i = 0; i < v; i++) begin
        a = base + 32'(i) * stride;
        if (st) model_ram[a[10:0]] = w[16*i +: 16];
        else    rd[16*i +: 16]     = model_ram[a[10:0]];
      end
    end
    lat    = (flt || v == 0) ? 2 : 3;
    we_exp = (st && !flt && v > 0) ? 1 : 0;
  endtask

  task automatic run(input logic st, input logic [31:0] base, input logic [31:0] stride,
                     input logic [4:0] vl, input logic [255:0] w, input int hold,
                     output logic [255:0] got_rd, output logic got_flt);
    int n, cyc, lat, we_exp, we0, diffs;
    logic [255:0] mrd;
    logic mflt;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    check("req_ready_idle", 256'(bus.req_ready), 256'd1);
    model(st, base, stride, vl, w, mrd, mflt, lat, we_exp);
    exp_rdata = mrd;
    exp_fault = mflt;
    we0 = we_cnt;
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_base   = base;
    bus.req_stride = stride;
    bus.req_vl     = vl;
    bus.req_wdata  = w;
    @(posedge clk); #1;
    // Junk on the request channel while busy must be ignored.
    bus.req_valid  = 1'($urandom);
    bus.req_store  = 1'($urandom);
    bus.req_base   = $urandom;
    bus.req_vl     = 5'($urandom);
    cyc = 1;
    while (1) begin
      @(negedge clk);
      if (bus.resp_valid || cyc >= 10) break;
      @(posedge clk);
      cyc++;
    end
    check("latency", 256'(cyc), 256'(lat));
    got_rd  = bus.resp_rdata;
    got_flt = bus.resp_fault;
    repeat (hold) @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check("mem_we_count", 256'(we_cnt - we0), 256'(we_exp));
    @(negedge clk);
    check("idle_after_resp", {254'd0, bus.req_ready, bus.resp_valid}, 256'b10);
    diffs = 0;
    for (int k = 0; k < MEM_DEPTH; k++) if (ram[k] !== model_ram[k]) diffs++;
    check("ram_image", 256'(diffs), 256'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] w, rd;
    logic flt;
    logic [31:0] b, s;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_base = '0;
    bus.req_stride = '0; bus.req_vl = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
    for (int k = 0; k < MEM_DEPTH; k++) model_ram[k] = 16'(k);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 256'(bus.req_ready), 256'd0);
    check("rst_resp_valid", 256'(bus.resp_valid), 256'd0);
    check("rst_mem_we", 256'(mem_we), 256'd0);
    @(posedge clk); #1;
    rst = 1'b0; preload = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 256'(bus.req_ready), 256'd1);
    check("post_rst_rdata", bus.resp_rdata, 256'd0);
    check("post_rst_fault", 256'(bus.resp_fault), 256'd0);
    check("post_rst_mem_addr", 256'(|mem_addr), 256'd0);
    check("post_rst_mem_wd", 256'(|mem_wd), 256'd0);

    // Unit-stride full load.
    run(1'b0, 32'd100, 32'd1, 5'd16, '0, 0, rd, flt);
    check("ld100_lane0", 256'(rd[15:0]), 256'd100);
    check("ld100_lane15", 256'(rd[255:240]), 256'd115);
    check("ld100_fault", 256'(flt), 256'd0);

    // Stride-2 partial store.
    w = '0;
    for (int i = 0; i < LANES; i++) w[16*i +: 16] = 16'hA000 + 16'(i);
    run(1'b1, 32'd200, 32'd2, 5'd4, w, 0, rd, flt);
    check("st_ram200", 256'(ram[200]), 256'hA000);
    check("st_ram206", 256'(ram[206]), 256'hA003);
    check("st_ram208", 256'(ram[208]), 256'd208);
    check("st_rdata", rd, 256'd0);

    // Out-of-range requests.
    run(1'b0, 32'd2040, 32'd1, 5'd16, '0, 0, rd, flt);
    check("oob_ld_fault", 256'(flt), 256'd1);
    check("oob_ld_rdata", rd, 256'd0);
    run(1'b1, 32'd2040, 32'd1, 5'd16, w, 0, rd, flt);
    check("oob_st_fault", 256'(flt), 256'd1);

    // Negative stride, then wrap below zero.
    run(1'b0, 32'd10, 32'hFFFF_FFFF, 5'd8, '0, 0, rd, flt);
    check("neg_lane7", 256'(rd[127:112]), 256'd3);
    check("neg_lane8", 256'(rd[143:128]), 256'd0);
    run(1'b0, 32'd10, 32'hFFFF_FFFF, 5'd12, '0, 0, rd, flt);
    check("neg_wrap_fault", 256'(flt), 256'd1);

    // Back-pressure on the response.
    run(1'b0, 32'd500, 32'd3, 5'd6, '0, 5, rd, flt);
    check("hold_lane5", 256'(rd[95:80]), 256'd515);

    // Reset during WRITE suppresses the store and drops the response.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_base = 32'd300;
    bus.req_stride = 32'd1; bus.req_vl = 5'd1; bus.req_wdata = {16{16'hBEEF}};
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_write_we", 256'(mem_we), 256'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_idle", {254'd0, bus.req_ready, bus.resp_valid}, 256'b10);
    check("abort_ram300", 256'(ram[300]), 256'd300);

    // vl=0 store and clamped vl=20 load.
    run(1'b1, 32'd400, 32'd1, 5'd0, w, 0, rd, flt);
    check("vl0_fault", 256'(flt), 256'd0);
    run(1'b0, 32'd50, 32'd3, 5'd20, '0, 0, rd, flt);
    check("vl20_lane15", 256'(rd[255:240]), 256'd95);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 8; k++) w[32*k +: 32] = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1990, 2100)) : 32'($urandom_range(0, 1980));
      s = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 8)) - 32'd4;
      run(1'($urandom), b, s, 5'($urandom_range(0, 20)), w, $urandom_range(0, 3), rd, flt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_lsu.md
# vector_lsu

Vector load/store unit sitting directly upstream of the 16-lane vector data memory (2048 × 16-bit words, 16 independent lane addresses, combinational read, synchronous write). It accepts one strided vector memory request from the pipeline MEM stage over a valid/ready handshake. It generates the 16 lane addresses, drives the memory's address/write ports, captures load data, and returns a response with a bounds-fault flag.

## Interface
- `LANES`, 16, number of vector lanes
- `LANE_W`, 16, bits per lane element
- `ADDR_W`, 32, lane address width
- `MEM_DEPTH`, 2048, number of valid memory words; addresses at or above it fault
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept a request
- `req_store`  in  1  1 = store, 0 = load
- `req_base`  in  ADDR_W  lane-0 word address
- `req_stride`  in  ADDR_W  two's-complement word stride between lanes
- `req_vl`  in  5  active vector length
- `req_wdata`  in  LANES*LANE_W  store data; lane i at [16i+15:16i]
- `resp_valid`  out  1  response present
- `resp_ready`  in  1  consumer takes response
- `resp_rdata`  out  LANES*LANE_W  load result
- `resp_fault`  out  1  out-of-range access; no memory effect
- `mem_addr`  out  LANES*ADDR_W  lane i address at [32i+31:32i] (memory ports a, a1..a15)
- `mem_we`  out  1  memory write enable
- `mem_wd`  out  LANES*LANE_W  memory write data
- `mem_rd`  in  LANES*LANE_W  memory combinational read data

## Operation
- FSM states: IDLE, CALC, READ, WRITE, RESP. Reset state is IDLE.
- **IDLE:** `req_ready`=1. On `req_valid && req_ready`, register `req_store`, `req_base`, `req_stride`, effective vl and `req_wdata`, then go to CALC.
- **Effective vl:** `req_vl` = 0 means no active lanes. `req_vl` > 16 is clamped to 16.
- **CALC:**
  - Lane address is `addr_i = req_base + i*req_stride`, modulo 2^32.
  - Inactive lanes (i ≥ vl) take the address and write data of lane vl-1.
  - The memory resolves same-address writes with the highest lane winning. Duplicated inactive lanes therefore write an identical value and never clobber active lanes.
  - Active-lane aliasing, e.g. stride 0, is not resolved: the highest active lane wins.
  - Register all addresses into `mem_addr`.
  - Fault = any active lane with unsigned `addr_i` ≥ MEM_DEPTH.
  - Next state: fault or vl=0 → RESP, with `resp_rdata`=0 and `resp_fault`=fault. Otherwise load → READ, store → WRITE.
- **READ:** capture `mem_rd` into `resp_rdata`, with inactive lanes forced to 0. Go to RESP.
- **WRITE:** `mem_we` = (state==WRITE) && !rst. `mem_wd` carries the merged data. Go to RESP. For a store response, `resp_rdata`=0.
- **RESP:** `resp_valid`=1, with data and fault held stable. On `resp_ready`, go to IDLE.
- `mem_we` is 0 in every state other than WRITE.
- `mem_addr` holds its last value outside CALC updates.

## Timing
- Reset values:
  - `req_ready`=1 from the first cycle after reset, because the reset state is IDLE.
  - `resp_valid`=0, `resp_fault`=0, `resp_rdata`=0, `mem_addr`=0, `mem_wd`=0, `mem_we`=0.
  - While `rst`=1, `req_ready`=0.
- Normal load/store: accept in cycle 0, CALC in cycle 1, READ/WRITE in cycle 2 (memory write lands at the end of cycle 2), `resp_valid` from cycle 3.
- Fault or vl=0: `resp_valid` from cycle 2, with no memory write.
- Back-to-back: when the response handshakes in cycle N, the state is IDLE in cycle N+1. Minimum initiation interval is 4 cycles.
- Reset mid-operation aborts to IDLE on the next edge and drops the pending response. Reset asserted during WRITE suppresses the write.
- `req_valid` is ignored outside IDLE. `resp_ready` is ignored outside RESP.

## Structure
- Package `vector_pkg` holds LANES, LANE_W, MEM_DEPTH and the enum `lsu_state_t` {IDLE, CALC, READ, WRITE, RESP}. The memory and future vector blocks share it.
- One combinational sub-module, `vector_addr_gen`:
  - Inputs: base, stride, vl.
  - Outputs: 16 lane addresses with inactive-lane replication, the active-lane mask, and fault.
- `vector_lsu` holds the FSM, registers and data merge.

## Test plan
- Bench instantiates `vector_lsu` wired to the vector memory preloaded with RAM[k]=k.
- Load, base=100, stride=1, vl=16: `resp_valid` in cycle 3, lane i = 100+i, fault=0.
- Store, base=200, stride=2, vl=4, wdata lane i = 0xA000+i: only RAM[200,202,204,206] = 0xA000..0xA003, RAM[208] unchanged at 208, `mem_we` high for exactly one cycle.
- Load, base=2040, stride=1, vl=16: fault=1, rdata=0, `resp_valid` in cycle 2. Same request as a store: no RAM changes.
- Load, base=10, stride=-1 (0xFFFFFFFF), vl=8: lanes 0..7 = 10..3, lanes 8..15 = 0. Same with vl=12: lane 11 address wraps to 0xFFFFFFFF, so fault=1.
- Hold `resp_ready`=0 for 5 cycles: response stable, `req_ready`=0. Assert `rst` during WRITE of a store to 300: RAM[300] unchanged, IDLE next cycle.
- vl=0 store and vl=20 load: the first gives no write and fault=0; the second behaves as vl=16.
